axi_ram_slave: RTL and testbench
================================

# axi_ram_slave

AXI3 slave responder that terminates the read and write channels driven by the CPU-side `cpu_axi_interface` master. It serves single-beat and short INCR/FIXED bursts from a single-port synchronous SRAM with 1-cycle read latency. It is used as the memory model and test target behind the CPU bridge, and as the on-chip RAM endpoint in small SoC configurations.

## Interface
- `ADDR_W`, default 14: SRAM word-address width. Capacity is 2^ADDR_W × 32 bit.
- `clk` in 1: the only clock; all logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `arid/araddr/arlen/arsize/arburst` in 4/32/8/3/2: AR payload.
- `arvalid` in 1, `arready` out 1: AR handshake.
- `rid/rdata/rresp/rlast` out 4/32/2/1: R payload.
- `rvalid` out 1, `rready` in 1: R handshake.
- `awid/awaddr/awlen/awsize/awburst` in 4/32/8/3/2: AW payload.
- `awvalid` in 1, `awready` out 1: AW handshake.
- `wdata/wstrb/wlast` in 32/4/1: W payload.
- `wvalid` in 1, `wready` out 1: W handshake.
- `bid/bresp` out 4/2: B payload.
- `bvalid` out 1, `bready` in 1: B handshake.
- `arlock/arcache/arprot/awlock/awcache/awprot/wid` in: accepted and ignored.
- `ram_en` out 1, `ram_wen` out 4, `ram_addr` out ADDR_W, `ram_wdata` out 32, `ram_rdata` in 32: SRAM port. `ram_rdata` is valid in the cycle after `ram_en && ram_wen==0`.

## Operation
- One transaction is in flight at a time; reads and writes are not overlapped.
- FSM states: IDLE, RD_ADDR, RD_LOAD, RD_DATA, WR_DATA, WR_RESP.
- **IDLE arbitration:**
  - Only `arvalid`: read is granted.
  - Only `awvalid`: write is granted.
  - Both asserted: grant goes to the type not served last. The `last_rd` flag resets to 0, so the first conflict goes to the read.
  - `arready = IDLE & arvalid & grant_rd`; `awready = IDLE & awvalid & grant_wr`.
- **AR/AW handshake latches:**
  - id, word address = addr[ADDR_W+1:2], byte offset, beats = len[3:0]+1, burst.
  - `len[7:4]` is ignored.
- **Read path:**
  - RD_ADDR: `ram_en`=1, `ram_wen`=0.
  - RD_LOAD: `rdata_q` <= `ram_rdata`.
  - RD_DATA: `rvalid`=1, `rdata`=`rdata_q`, `rid`=latched id, `rresp`=OKAY, `rlast`=(beat==last).
  - On `rvalid & rready`: if last beat, go to IDLE; else advance the address and go to RD_ADDR.
- **Write path:**
  - WR_DATA: `wready`=1.
  - On `wvalid`: `ram_en`=1, `ram_wen`=`wstrb`, `ram_wdata`=`wdata`, address advances.
  - After the final beat (by count), go to WR_RESP.
  - `wlast` mismatch with the counted beat: the count governs and `bresp`=SLVERR.
  - WR_RESP: `bvalid`=1, `bid`=latched id. On `bready`, go to IDLE.
- **Address advance:**
  - INCR: byte address += 1<<min(size,2), wrapping modulo 2^(ADDR_W+2).
  - FIXED: no change.
  - WRAP: treated as INCR.
- **Narrow transfers:** reads always return the full aligned word; writes use `wstrb` as given.
- Address bits above ADDR_W+1 are ignored (aliasing); there is no DECERR.

## Timing
- **Reset values** (asynchronous, held while `resetn`=0):
  - state=IDLE, `last_rd`=0.
  - `rvalid`, `bvalid`, `wready`, `ram_en`, `ram_wen` = 0.
  - `rdata_q`, `rid`, `bid`, `rresp`, `bresp`, `rlast` = 0.
  - `arready`/`awready` are 0 because the master's valids are low under reset.
- **Read latency:** AR handshake at cycle T, `ram_en` at T+1, `rvalid` at T+3. Each further burst beat is 3 cycles after the previous R handshake.
- **Write:** AW handshake at T, `wready` from T+1. One beat per cycle with `wvalid` held. `bvalid` is asserted the cycle after the last W handshake.
- `rvalid`/`bvalid`, once raised, hold with payload stable until the handshake.
- `wvalid` arriving before or with `awvalid` (as our master does) is legal; W simply waits for WR_DATA.
- Reset mid-transaction aborts it. No response is issued for the aborted transaction.

## Structure
- Shared package `axi_pkg`:
  - `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10.
  - `BURST_FIXED`=2'b00, `BURST_INCR`=2'b01, `BURST_WRAP`=2'b10.
  - The state encoding.
- Sub-module `sp_sram` (ADDR_W × 32, byte-write enables, registered read), instantiated in test builds. Synthesis builds map the `ram_*` port to a BRAM macro.

## Test plan
- Single write then read: AW addr 0x100, wdata 0xDEADBEEF, wstrb 4'hF, then AR 0x100. Required: `bresp`=0, `rdata`=0xDEADBEEF, `rlast`=1, `rid` = `arid`.
- Byte write: wstrb 4'b0100, wdata 0x00AB0000 to 0x100 (holding 0xDEADBEEF). Required: readback 0xDEABBEEF.
- INCR burst: awlen 3 from 0x200, data 1..4, then arlen 3 read. Required: 1,2,3,4, with `rlast` only on beat 4 and `rready` toggled randomly.
- Simultaneous `arvalid`+`awvalid` twice in a row. Required: read granted first, then the write, then the next conflict also alternates.
- FIXED burst: awlen 1 to 0x300, data 5 then 6. Required: read of 0x300 returns 6; `wlast` asserted early on beat 1 gives `bresp`=SLVERR.
- `resetn` pulsed low while in RD_DATA. Required: `rvalid` drops asynchronously, FSM returns to IDLE, and the next AR completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI3 response/burst encodings and the RAM slave state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_LOAD = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } ram_state_e;

  // Bytes per beat; anything wider than the 32-bit bus is clamped to 4.
  function automatic logic [2:0] beat_bytes(input logic [2:0] size);
    return (size >= 3'd2) ? 3'd4 : (3'd1 << size);
  endfunction

endpackage

// File: rtl/sp_sram.sv
// Single-port 32-bit SRAM with byte write enables and a registered read port.
module sp_sram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (wen == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave terminating one read or write transaction at a time onto a
// single-port SRAM with 1-cycle read latency.
//
// state   | meaning
// IDLE    | arbitrate AR vs AW, latch the granted request
// RD_ADDR | drive SRAM read for the current beat
// RD_LOAD | capture SRAM read data
// RD_DATA | present R beat, wait for rready
// WR_DATA | accept W beats, one SRAM write per beat
// WR_RESP | present B response, wait for bready
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  ram_state_e state, state_nxt;

  logic              last_rd;
  logic [3:0]        id_q;
  logic [ADDR_W+1:0] addr_q;
  logic [3:0]        len_q;
  logic [3:0]        beat_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [31:0]       rdata_q;
  logic              slverr_q;

  logic              grant_rd;
  logic              grant_wr;
  logic              last_beat;
  logic [ADDR_W+1:0] addr_nxt;

  // Sideband and upper address/length bits carry no meaning for this RAM.
  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                           araddr[31:ADDR_W+2], awaddr[31:ADDR_W+2],
                           arlen[7:4], awlen[7:4]};

  assign grant_rd  = arvalid & (~awvalid | ~last_rd);
  assign grant_wr  = awvalid & ~grant_rd;
  assign last_beat = (beat_q == len_q);
  assign addr_nxt  = (burst_q == BURST_FIXED) ? addr_q
                   : addr_q + {{(ADDR_W-1){1'b0}}, beat_bytes(size_q)};

  assign rid       = id_q;
  assign bid       = id_q;
  assign rdata     = rdata_q;
  assign rresp     = RESP_OKAY;
  assign rlast     = (state == RD_DATA) & last_beat;
  assign bresp     = slverr_q ? RESP_SLVERR : RESP_OKAY;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      last_rd <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (grant_rd)      last_rd <= 1'b1;
        else if (grant_wr) last_rd <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    rvalid    = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    ram_en    = 1'b0;
    ram_wen   = 4'b0000;
    case (state)
      IDLE: begin
        arready = grant_rd;
        awready = grant_wr;
        if (grant_rd)      state_nxt = RD_ADDR;
        else if (grant_wr) state_nxt = WR_DATA;
      end
      RD_ADDR: begin
        ram_en    = 1'b1;
        state_nxt = RD_LOAD;
      end
      RD_LOAD: state_nxt = RD_DATA;
      RD_DATA: begin
        rvalid = 1'b1;
        if (rready) state_nxt = last_beat ? IDLE : RD_ADDR;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en  = 1'b1;
          ram_wen = wstrb;
          if (last_beat) state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd | grant_wr) begin
            id_q     <= grant_rd ? arid : awid;
            addr_q   <= grant_rd ? araddr[ADDR_W+1:0] : awaddr[ADDR_W+1:0];
            len_q    <= grant_rd ? arlen[3:0] : awlen[3:0];
            size_q   <= grant_rd ? arsize : awsize;
            burst_q  <= grant_rd ? arburst : awburst;
            beat_q   <= '0;
            slverr_q <= 1'b0;
          end
        end
        RD_LOAD: rdata_q <= ram_rdata;
        RD_DATA: begin
          if (rready && !last_beat) begin
            addr_q <= addr_nxt;
            beat_q <= beat_q + 4'd1;
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            addr_q <= addr_nxt;
            beat_q <= beat_q + 4'd1;
            // The beat count is authoritative; a disagreeing wlast only flags an error.
            if (wlast != last_beat) slverr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave backed by sp_sram.
module tb_axi_ram_slave;
  import axi_pkg::*;

  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] arid = '0;  logic [31:0] araddr = '0; logic [7:0] arlen = '0;
  logic [2:0] arsize = '0; logic [1:0] arburst = '0; logic arvalid = 1'b0;
  logic [3:0] awid = '0;  logic [31:0] awaddr = '0; logic [7:0] awlen = '0;
  logic [2:0] awsize = '0; logic [1:0] awburst = '0; logic awvalid = 1'b0;
  logic [31:0] wdata = '0; logic [3:0] wstrb = '0; logic wlast = 1'b0; logic wvalid = 1'b0;
  logic rready = 1'b0; logic bready = 1'b0;
  logic arready, awready, rvalid, rlast, wready, bvalid;
  logic [3:0] rid, bid; logic [31:0] rdata; logic [1:0] rresp, bresp;
  logic ram_en; logic [3:0] ram_wen; logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_ram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000), .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  sp_sram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .en(ram_en), .wen(ram_wen), .addr(ram_addr),
    .wdata(ram_wdata), .rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return arready;
      1: return awready;
      2: return wready;
      3: return rvalid;
      default: return bvalid;
    endcase
  endfunction

  // Returns at a negedge where the selected signal is high, or after a bounded wait.
  task automatic wait_sig(input string tag, input int sel);
    int n = 0;
    @(negedge clk);
    while (!sig(sel) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!sig(sel)) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] burst);
    arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    wait_sig("arready", 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    wait_sig("awready", 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    wait_sig("wready", 2);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] r, output logic [3:0] id);
    bready = 1'b1;
    wait_sig("bvalid", 4);
    r = bresp; id = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic r_take(input bit rnd, output logic [31:0] d, output logic l, output logic [3:0] id);
    int n = 0;
    rready = 1'b0;
    wait_sig("rvalid", 3);
    while (rnd && $urandom_range(0, 1) == 0 && n < 6) begin
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1'b1);
      n++;
    end
    rready = 1'b1;
    d = rdata; l = rlast; id = rid;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        l;
    logic [3:0]  id;
    logic [1:0]  r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {rvalid, bvalid, wready, ram_en, ram_wen, arready, awready, rlast}, 32'd0);
    chk("rst_ids", {rid, bid, rresp, bresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // First conflict after reset goes to the read.
    arid = 4'd1; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
    awid = 4'd2; awaddr = 32'h44; awlen = 8'd0; awsize = 3'd2; awburst = BURST_INCR;
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge clk);
    chk("arb1_grant", {arready, awready}, 2'b10);
    @(posedge clk); #1; arvalid = 1'b0;
    r_take(0, d, l, id);
    chk("arb1_rid", id, 4'd1);
    wait_sig("awready", 1);
    @(posedge clk); #1; awvalid = 1'b0;
    w_beat(32'h1111_1111, 4'hF, 1'b1);
    b_take(r, id);
    chk("arb1_b", {id, r}, {4'd2, RESP_OKAY});

    // Last served was a write: read wins, then the held write wins the next conflict.
    arid = 4'd3; araddr = 32'h44; arlen = 8'd0;
    awid = 4'd4; awaddr = 32'h48; awlen = 8'd0;
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge clk);
    chk("arb2_grant", {arready, awready}, 2'b10);
    @(posedge clk); #1; arvalid = 1'b0;
    r_take(0, d, l, id);
    chk("arb2_rdata", d, 32'h1111_1111);
    chk("arb2_rid", id, 4'd3);
    arid = 4'd5; araddr = 32'h48; arvalid = 1'b1;
    @(negedge clk);
    chk("arb3_grant", {arready, awready}, 2'b01);
    @(posedge clk); #1; awvalid = 1'b0;
    w_beat(32'h2222_2222, 4'hF, 1'b1);
    b_take(r, id);
    chk("arb3_bid", id, 4'd4);
    wait_sig("arready", 0);
    @(posedge clk); #1; arvalid = 1'b0;
    r_take(0, d, l, id);
    chk("arb3_rdata", d, 32'h2222_2222);
    chk("arb3_rid", id, 4'd5);

    // Single write then read with latency checks.
    aw_hs(4'd6, 32'h100, 8'd0, BURST_INCR);
    w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
    chk("w1_bvalid_next", bvalid, 1'b1);
    b_take(r, id);
    chk("w1_bresp", r, RESP_OKAY);
    ar_hs(4'd7, 32'h100, 8'd0, BURST_INCR);
    chk("r1_ram_en_t1", ram_en, 1'b1);
    @(posedge clk); #1;
    chk("r1_rvalid_t2", rvalid, 1'b0);
    @(posedge clk); #1;
    chk("r1_rvalid_t3", rvalid, 1'b1);
    r_take(0, d, l, id);
    chk("r1_rdata", d, 32'hDEAD_BEEF);
    chk("r1_rlast", l, 1'b1);
    chk("r1_rid", id, 4'd7);

    // Byte write into lane 2.
    aw_hs(4'd1, 32'h100, 8'd0, BURST_INCR);
    w_beat(32'h00AB_0000, 4'b0100, 1'b1);
    b_take(r, id);
    ar_hs(4'd2, 32'h100, 8'd0, BURST_INCR);
    r_take(0, d, l, id);
    chk("byte_rdata", d, 32'hDEAB_BEEF);

    // INCR burst of 4 with random rready back-pressure.
    aw_hs(4'd8, 32'h200, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) w_beat(32'(i + 1), 4'hF, i == 3);
    b_take(r, id);
    chk("incr_bresp", r, RESP_OKAY);
    ar_hs(4'd9, 32'h200, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      r_take(1, d, l, id);
      chk("incr_rdata", d, 32'(i + 1));
      chk("incr_rlast", l, i == 3);
    end
    ar_hs(4'd9, 32'h208, 8'd0, BURST_INCR);
    r_take(0, d, l, id);
    chk("incr_word2", d, 32'd3);

    // FIXED burst, wlast asserted on the first of two beats.
    aw_hs(4'd10, 32'h300, 8'd1, BURST_FIXED);
    w_beat(32'd5, 4'hF, 1'b1);
    w_beat(32'd6, 4'hF, 1'b0);
    b_take(r, id);
    chk("fixed_bresp", r, RESP_SLVERR);
    chk("fixed_bid", id, 4'd10);
    ar_hs(4'd11, 32'h300, 8'd0, BURST_INCR);
    r_take(0, d, l, id);
    chk("fixed_rdata", d, 32'd6);

    // Reset while R beat is pending.
    ar_hs(4'd12, 32'h100, 8'd0, BURST_INCR);
    wait_sig("rvalid", 3);
    resetn = 1'b0;
    #1;
    chk("rst_rvalid_async", rvalid, 1'b0);
    @(negedge clk);
    chk("rst_hold_rvalid", rvalid, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;
    ar_hs(4'd13, 32'h100, 8'd0, BURST_INCR);
    r_take(0, d, l, id);
    chk("post_rst_rdata", d, 32'hDEAB_BEEF);
    chk("post_rst_rid", id, 4'd13);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
